ifm_feeder: RTL
===============

Name: ifm_feeder

Overview:
- Source-side streamer for the 4-tap IFM shift buffer.
- Reads an IMG_W x IMG_H input feature map, stored row-major in a synchronous-read SRAM with 1-cycle read latency.
- Presents pixels one per strobe on ifm_input/ifm_read, in row order, left to right.
- Flags with win_valid when the downstream shift buffer holds TAPS pixels from the same row. Controlled by a start/busy/done handshake with a stall input.

Parameters:
- DATA_W, 8: pixel width, signed.
- IMG_W, 8: image width in pixels.
- IMG_H, 8: image height in pixels.
- TAPS, 4: window depth of the downstream shift buffer.
- ADDR_W, 6: SRAM address width. Must satisfy IMG_W*IMG_H <= 2**ADDR_W.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- start, input, 1: begin one frame; sampled only in IDLE.
- stall, input, 1: when high, blocks issue of new SRAM reads.
- mem_rd_en, output, 1: SRAM read enable.
- mem_addr, output, ADDR_W: SRAM read address; equals row*IMG_W+col.
- mem_rdata, input, DATA_W: SRAM read data; valid the cycle after mem_rd_en.
- ifm_input, output, DATA_W: pixel to the shift buffer; wired directly from mem_rdata.
- ifm_read, output, 1: shift strobe; mem_rd_en delayed by one register stage.
- win_valid, output, 1: shift-buffer contents form a valid TAPS-wide window of one row.
- busy, output, 1: high in RUN and DRAIN.
- done, output, 1: one-cycle pulse at end of frame.

Behaviour:
- Reset is asynchronous and returns to IDLE. During reset:
  - mem_rd_en, mem_addr, ifm_read, win_valid, busy and done are all 0.
  - Row/col counters and all pipeline registers are 0.
  - ifm_input follows mem_rdata at all times; it is meaningful only while ifm_read=1.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 at an edge -> RUN.
  - start in any other state is ignored.
- RUN:
  - Each cycle with stall=0: mem_rd_en=1 and mem_addr = row*IMG_W+col.
  - col increments; at col=IMG_W-1, col wraps to 0 and row increments.
  - Each cycle with stall=1: mem_rd_en=0, and the counters and mem_addr hold.
  - When address IMG_W*IMG_H-1 is issued -> DRAIN.
- DRAIN:
  - One cycle, mem_rd_en=0.
  - The last pixel is delivered (ifm_read=1). Stall is ignored.
  - -> DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0 -> IDLE.
  - A start during DONE is ignored.
- Read-to-strobe timing:
  - ifm_read(t+1) = mem_rd_en(t).
  - The column of each issued read is pipelined alongside it as col_d.
- Stall rules:
  - stall never cancels a read already in flight; the pixel requested in cycle t is always delivered in t+1.
  - stall has no effect in IDLE, DRAIN or DONE.
- win_valid:
  - Registered: win_valid(t+1) = ifm_read(t) AND col_d(t) >= TAPS-1.
  - This aligns it with the shift-buffer outputs after capture.
  - It is low for the first TAPS-1 pixels of every row, so windows never straddle rows.
- Per frame, no stalls:
  - IMG_W*IMG_H ifm_read strobes and IMG_H*(IMG_W-TAPS+1) win_valid pulses.
  - Frame latency: start sampled at edge 0; RUN occupies cycles 1..IMG_W*IMG_H; DRAIN follows; DONE follows DRAIN.
  - The final win_valid coincides with done.
- Each stall cycle in RUN delays done by exactly one cycle.
- Reset mid-frame: immediate abort to IDLE with all outputs 0. No done pulse.

Test Plan:
- Reset: assert rst_n=0 mid-RUN -> all outputs 0 within the same cycle. After release the block stays IDLE, with no mem_rd_en until start.
- Basic frame, default params, mem[a]=a:
  - Pulse start at cycle 0 -> mem_addr 0..63 on cycles 1..64.
  - ifm_input 0..63 with ifm_read on cycles 2..65.
  - done=1 on cycle 66, busy=0 on cycle 66.
  - Exactly 64 ifm_read strobes and 40 win_valid pulses.
- Row windows:
  - No win_valid after pixels 0-2 or 8-10.
  - win_valid in the cycle after pixel 3 is strobed; the bench shift buffer then shows 3,2,1,0.
  - win_valid in the cycle after pixel 11 is strobed; the bench shift buffer shows 11,10,9,8.
- Stall: stall=1 for 3 cycles when the next col=5 of row 2 (addr 21) is due:
  - mem_rd_en=0 and mem_addr=21 held for those 3 cycles.
  - The in-flight pixel 20 is still strobed.
  - The ifm_input sequence is unbroken, and done moves to cycle 69.
- Ignored start:
  - start pulses at cycles 10 and 66 -> no restart and no address disturbance.
  - The block is IDLE at cycle 67; a new start at 67 begins a second identical frame.
- Abort/restart: reset at cycle 30, release, then start -> the frame restarts from address 0 with full counts of 64 strobes and 40 windows.

Source files
------------

// File: rtl/ifm_feeder.sv
// Source-side streamer for the IFM shift buffer: walks the feature map row-major out of a
// 1-cycle-latency SRAM and strobes each pixel into the shift buffer, flagging row-local windows.
module ifm_feeder #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int TAPS   = 4,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ifm_input,
    output logic              ifm_read,
    output logic              win_valid,
    output logic              busy,
    output logic              done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [CW-1:0]     LAST_COL  = CW'(IMG_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic              issue_s;
    logic [CW-1:0]     col_r;
    logic [RW-1:0]     row_r;
    logic [ADDR_W-1:0] addr_r;
    logic [CW-1:0]     col_d_r;
    logic              ifm_read_r;
    logic              win_valid_r;

    // A read is issued every unstalled RUN cycle; stall gates only new issues.
    assign issue_s = (state_r == RUN) && !stall;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (issue_s && (addr_r == LAST_ADDR)) begin
                    state_s = DRAIN;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN:   state_s = DONE;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Row/column/address counters; they return to 0 after the last pixel is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r  <= '0;
            row_r  <= '0;
            addr_r <= '0;
        end else if (issue_s) begin
            if (addr_r == LAST_ADDR) begin
                col_r  <= '0;
                row_r  <= '0;
                addr_r <= '0;
            end else if (col_r == LAST_COL) begin
                col_r  <= '0;
                row_r  <= row_r + RW'(1);
                addr_r <= addr_r + ADDR_W'(1);
            end else begin
                col_r  <= col_r + CW'(1);
                addr_r <= addr_r + ADDR_W'(1);
            end
        end else begin
            col_r  <= col_r;
            row_r  <= row_r;
            addr_r <= addr_r;
        end
    end

    // Strobe and column travel one stage behind the read, matching SRAM latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifm_read_r <= 1'b0;
            col_d_r    <= '0;
        end else begin
            ifm_read_r <= issue_s;
            if (issue_s) begin
                col_d_r <= col_r;
            end else begin
                col_d_r <= col_d_r;
            end
        end
    end

    // Window flag lines up with the shift buffer after it has captured the strobed pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid_r <= 1'b0;
        end else begin
            win_valid_r <= ifm_read_r && (int'(col_d_r) >= TAPS - 1);
        end
    end

    assign mem_rd_en = issue_s;
    assign mem_addr  = addr_r;
    assign ifm_input = mem_rdata;
    assign ifm_read  = ifm_read_r;
    assign win_valid = win_valid_r;
    assign busy      = (state_r == RUN) || (state_r == DRAIN);
    assign done      = (state_r == DONE);

endmodule
